// File: rtl/code_conv_pkg.sv
// Shared constants and types for the arbitrated code-conversion block.
package code_conv_pkg;
    localparam int DIN_W  = 4;
    localparam int DOUT_W = 5;
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_BIN2BCD  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_BIN2GRAY = 3'd1;
    localparam logic [MODE_W-1:0] MODE_GRAY2BIN = 3'd2;
    localparam logic [MODE_W-1:0] MODE_BIN2EX3  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_EX3BIN   = 3'd4;

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
endpackage

// File: rtl/code_conv_core.sv
// Combinational 4-bit code converter; result is zero-extended to DOUT_W.
module code_conv_core
    import code_conv_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic [DIN_W-1:0]  din,
    output logic [DOUT_W-1:0] dout,
    output logic              err
);
    always_comb begin
        dout = '0;
        err  = 1'b0;
        case (mode)
            MODE_BIN2BCD: begin
                if (din >= 4'd10) dout = {1'b1, din - 4'd10};
                else              dout = {1'b0, din};
            end
            MODE_BIN2GRAY: dout = {1'b0, din ^ (din >> 1)};
            MODE_GRAY2BIN: dout = {1'b0, din[3], ^din[3:2], ^din[3:1], ^din[3:0]};
            MODE_BIN2EX3:  dout = {1'b0, din} + 5'd3;
            MODE_EX3BIN: begin
                // Only 3..12 are legal excess-3 digits
                if (din < 4'd3 || din > 4'd12) err = 1'b1;
                else                           dout = {1'b0, din - 4'd3};
            end
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/code_conv_arbiter.sv
// Round-robin front end sharing one code_conv_core among N_REQ requesters,
// with a registered convert stage and a valid/ready result port.
module code_conv_arbiter
    import code_conv_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [MODE_W*N_REQ-1:0] mode,
    input  logic [DIN_W*N_REQ-1:0]  din,
    output logic [N_REQ-1:0]        gnt,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [DOUT_W-1:0]       res_data,
    output logic                    res_err
);
    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     win_idx;
    logic                win_found;
    logic [MODE_W-1:0]   win_mode, cap_mode;
    logic [DIN_W-1:0]    win_din, cap_din;
    logic [ID_W-1:0]     cap_id;
    logic [DOUT_W-1:0]   core_dout;
    logic                core_err;

    // Rotating search starting just after the last winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_mode = '0;
        win_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_mode = mode[MODE_W*i +: MODE_W];
                win_din  = din[DIN_W*i +: DIN_W];
            end
        end
        gnt = '0;
        if (rst_n && state_q == IDLE && win_found) gnt[win_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = CONV;
            CONV:    state_d = RESP;
            RESP:    if (res_valid && res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    code_conv_core u_core (
        .mode (cap_mode),
        .din  (cap_din),
        .dout (core_dout),
        .err  (core_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= ID_W'(N_REQ - 1);
            cap_mode  <= '0;
            cap_din   <= '0;
            cap_id    <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (win_found) begin
                    ptr      <= win_idx;
                    cap_mode <= win_mode;
                    cap_din  <= win_din;
                    cap_id   <= win_idx;
                end
                CONV: begin
                    res_valid <= 1'b1;
                    res_data  <= core_dout;
                    res_err   <= core_err;
                    res_id    <= cap_id;
                end
                RESP: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
